// File: rtl/display_scan_ctrl_if.sv
// PicoBlaze port I/O bus as seen by a peripheral.
//   master : processor side, drives address, write data and strobes
//   slave  : peripheral side, returns registered read data
// Signals:
//   port_id      8  port address
//   data_in      8  write data (processor -> peripheral)
//   data_out     8  read data (peripheral -> processor)
//   read_strobe  1  read qualifier
//   write_strobe 1  write qualifier
interface display_scan_ctrl_if;
    logic [7:0] port_id;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       read_strobe;
    logic       write_strobe;

    modport master (
        output port_id,
        output data_in,
        output read_strobe,
        output write_strobe,
        input  data_out
    );

    modport slave (
        input  port_id,
        input  data_in,
        input  read_strobe,
        input  write_strobe,
        output data_out
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// Multiplexed seven-segment display controller on the PicoBlaze port bus.
// Holds one register per digit plus a control register, decodes hex nibbles
// to segments and scans the digits onto shared cathodes with a programmable
// tick rate and 16-level brightness PWM.
// Ports:
//   clk      system clock
//   reset    asynchronous, active-high reset
//   bus      port I/O bus (slave modport): port_id, data_in, data_out,
//            read_strobe, write_strobe
//   anode    digit select, one-hot when lit (polarity per ACTIVE_LOW)
//   cathode  segments {dp,g,f,e,d,c,b,a} (polarity per ACTIVE_LOW)
// Register map (relative to BASE_ADDRESS):
//   0..NUM_DIGITS-1  digit: [3:0] hex, [4] dp, [5] blank
//   NUM_DIGITS       control: [0] enable, [7:4] brightness
//   NUM_DIGITS+1     status (read-only): [2:0] digit index, [3] lit
module display_scan_ctrl #(
    parameter logic [7:0]  BASE_ADDRESS = 8'h00,
    parameter int          NUM_DIGITS   = 4,
    parameter logic [15:0] REFRESH_DIV  = 16'd3125,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    display_scan_ctrl_if.slave     bus,
    output logic [NUM_DIGITS-1:0]  anode,
    output logic [7:0]             cathode
);

    localparam int          IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [7:0]  NUM_D8     = 8'(NUM_DIGITS);
    localparam logic [7:0]  CTRL_OFS   = 8'(NUM_DIGITS);
    localparam logic [7:0]  STAT_OFS   = 8'(NUM_DIGITS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [15:0] PRESC_LAST = REFRESH_DIV - 16'd1;

    typedef enum logic {
        DISABLED = 1'b0,
        SCANNING = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            bright_q;
    logic [5:0]            digit_q [NUM_DIGITS];
    logic [15:0]           presc_q, presc_d;
    logic [3:0]            pwm_q, pwm_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  lit_q;
    logic [IDX_W-1:0]      disp_idx_q;

    logic [7:0]            offset;
    logic [IDX_W-1:0]      sel;
    logic                  digit_hit;
    logic                  ctrl_wr;
    logic                  tick;
    logic                  lit;
    logic [NUM_DIGITS-1:0] anode_d;
    logic [7:0]            cathode_d;
    logic [7:0]            rd_d;

    // Reads have no side effects, so the read qualifier is not needed.
    logic unused_ok;
    assign unused_ok = &{1'b0, bus.read_strobe};

    function automatic logic [7:0] seg_decode(input logic [5:0] d);
        logic [6:0] seg;
        if (d[5]) begin
            return 8'h00;
        end
        case (d[3:0])
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return {d[4], seg};
    endfunction

    // Offset wraps to a large value below BASE_ADDRESS, so a single
    // unsigned compare covers both range ends.
    assign offset    = bus.port_id - BASE_ADDRESS;
    assign sel       = offset[IDX_W-1:0];
    assign digit_hit = (offset < NUM_D8);
    assign ctrl_wr   = bus.write_strobe && (offset == CTRL_OFS);
    assign tick      = (presc_q == PRESC_LAST);

    // Register file writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bright_q <= 4'hF;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= 6'h00;
            end
        end else begin
            if (bus.write_strobe && digit_hit) begin
                digit_q[sel] <= bus.data_in[5:0];
            end
            if (ctrl_wr) begin
                bright_q <= bus.data_in[7:4];
            end
        end
    end

    // Scan state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SCANNING;
            presc_q <= 16'd0;
            pwm_q   <= 4'd0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            pwm_q   <= pwm_d;
            idx_q   <= idx_d;
        end
    end

    // Next scan state and display outputs
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        pwm_d     = pwm_q;
        idx_d     = idx_q;
        lit       = 1'b0;
        anode_d   = '0;
        cathode_d = 8'h00;

        if (ctrl_wr) begin
            state_d = bus.data_in[0] ? SCANNING : DISABLED;
        end

        case (state_q)
            DISABLED: begin
                presc_d = 16'd0;
                pwm_d   = 4'd0;
                idx_d   = '0;
            end
            SCANNING: begin
                // A disabling write overrides a coincident tick.
                if (ctrl_wr && !bus.data_in[0]) begin
                    presc_d = 16'd0;
                    pwm_d   = 4'd0;
                    idx_d   = '0;
                end else if (tick) begin
                    presc_d = 16'd0;
                    pwm_d   = pwm_q + 4'd1;
                    if (pwm_q == 4'hF) begin
                        idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
                    end
                end else begin
                    presc_d = presc_q + 16'd1;
                end
                lit = (pwm_q <= bright_q);
            end
            default: begin
                state_d = DISABLED;
            end
        endcase

        if (lit) begin
            anode_d[idx_q] = 1'b1;
            cathode_d      = seg_decode(digit_q[idx_q]);
        end
    end

    // Output pin registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anode      <= {NUM_DIGITS{ACTIVE_LOW}};
            cathode    <= {8{ACTIVE_LOW}};
            lit_q      <= 1'b0;
            disp_idx_q <= '0;
        end else begin
            anode      <= anode_d ^ {NUM_DIGITS{ACTIVE_LOW}};
            cathode    <= cathode_d ^ {8{ACTIVE_LOW}};
            lit_q      <= lit;
            disp_idx_q <= idx_q;
        end
    end

    // Read mux
    always_comb begin
        rd_d = 8'h00;
        if (digit_hit) begin
            rd_d = {2'b00, digit_q[sel]};
        end else if (offset == CTRL_OFS) begin
            rd_d = {bright_q, 3'b000, (state_q == SCANNING)};
        end else if (offset == STAT_OFS) begin
            rd_d = {4'h0, lit_q, 3'(disp_idx_q)};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.data_out <= 8'h00;
        end else begin
            bus.data_out <= rd_d;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=2,
// ACTIVE_LOW=1. Each digit slot lasts 32 clk.
module tb_display_scan_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] anode;
    logic [7:0] cathode;
    int         n_checks;
    int         n_fail;

    display_scan_ctrl_if bus ();

    display_scan_ctrl #(
        .BASE_ADDRESS (8'h00),
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (16'd2),
        .ACTIVE_LOW   (1'b1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .anode   (anode),
        .cathode (cathode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        bus.port_id      = a;
        bus.data_in      = d;
        bus.write_strobe = 1'b1;
        @(posedge clk);
        #1;
        bus.write_strobe = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
        bus.port_id = a;
        @(posedge clk);
        #1;
        check(tag, {24'h0, bus.data_out}, {24'h0, exp});
    endtask

    task automatic pins(input string tag, input logic [3:0] an, input logic [7:0] ca);
        check({tag, "_anode"}, {28'h0, anode}, {28'h0, an});
        check({tag, "_cathode"}, {24'h0, cathode}, {24'h0, ca});
    endtask

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        reset            = 1'b1;
        bus.port_id      = 8'h00;
        bus.data_in      = 8'h00;
        bus.read_strobe  = 1'b0;
        bus.write_strobe = 1'b0;

        // Reset state
        step(2);
        pins("reset", 4'hF, 8'hFF);
        check("reset_data_out", {24'h0, bus.data_out}, 32'h0);
        reset = 1'b0;
        rd("ctrl_reset", 8'h04, 8'hF1);

        // Write/readback, unmapped read
        wr(8'h01, 8'hFF);
        rd("digit1_rb", 8'h01, 8'h3F);
        rd("unmapped", 8'h20, 8'h00);

        // Scan at brightness 15: digits 1,2,3,8
        wr(8'h04, 8'h00);
        wr(8'h00, 8'h01);
        wr(8'h01, 8'h02);
        wr(8'h02, 8'h03);
        wr(8'h03, 8'h08);
        wr(8'h04, 8'hF1);
        step(1);
        pins("slot0_start", 4'hE, 8'hF9);
        step(31);
        pins("slot0_end", 4'hE, 8'hF9);
        step(1);
        pins("slot1", 4'hD, 8'hA4);
        step(32);
        pins("slot2", 4'hB, 8'hB0);
        step(32);
        pins("slot3", 4'h7, 8'h80);
        step(32);
        pins("wrap", 4'hE, 8'hF9);
        rd("status_lit", 8'h05, 8'h08);

        // Brightness 3: lit 8 clk, off 24 clk
        wr(8'h04, 8'h00);
        wr(8'h04, 8'h31);
        step(8);
        pins("b3_lit_end", 4'hE, 8'hF9);
        step(1);
        pins("b3_off", 4'hF, 8'hFF);
        step(23);
        pins("b3_off_end", 4'hF, 8'hFF);
        step(1);
        pins("b3_slot1", 4'hD, 8'hA4);

        // Blank digit 2, digit 0 = A with dp
        wr(8'h02, 8'h30);
        wr(8'h00, 8'h1A);
        wr(8'h04, 8'h00);
        wr(8'h04, 8'hF1);
        step(1);
        pins("dp_a", 4'hE, 8'h08);
        step(64);
        pins("blank", 4'hB, 8'hFF);

        // Disable mid-slot
        step(5);
        wr(8'h04, 8'h00);
        check("dis_hold_anode", {28'h0, anode}, 32'hB);
        step(1);
        pins("disabled", 4'hF, 8'hFF);
        rd("status_off", 8'h05, 8'h00);

        // Re-enable restarts at digit 0
        wr(8'h04, 8'hF1);
        step(1);
        pins("reenable", 4'hE, 8'h08);
        step(40);
        pins("reen_slot1", 4'hD, 8'hA4);

        // Asynchronous reset mid-slot
        reset = 1'b1;
        #1;
        pins("async_reset", 4'hF, 8'hFF);
        check("async_data_out", {24'h0, bus.data_out}, 32'h0);
        step(1);
        reset = 1'b0;
        rd("ctrl_after_rst", 8'h04, 8'hF1);
        rd("digit0_after_rst", 8'h00, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
